// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the load/store sequencer: funct3 codes, FSM states
// and the address alignment helper.
package dmem_lsu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } state_t;

    // Low address bits forced to the natural alignment of the access width.
    function automatic logic [1:0] natural_align(input logic [2:0] f3, input logic [1:0] lo);
        logic [1:0] r;
        r = lo;
        case (f3)
            F3_H, F3_HU: r = {lo[1], 1'b0};
            F3_W:        r = 2'b00;
            default:     r = lo;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane logic: load extraction with sign/zero extension, sub-word
// store merge, and funct3 legality / alignment checks.
module dmem_lane_align
    import dmem_lsu_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        addr_lo,
    input  logic [2:0]        funct3,
    input  logic              is_store,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_val,
    output logic [DATA_W-1:0] store_word,
    output logic              misaligned,
    output logic              illegal
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
        logic signed [7:0]        sb;
        logic signed [DATA_W-1:0] sw;
        sb = signed'(b);
        sw = DATA_W'(sb);
        return sgn ? DATA_W'(sw) : {{(DATA_W-8){1'b0}}, b};
    endfunction

    function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
        logic signed [15:0]       sh;
        logic signed [DATA_W-1:0] sw;
        sh = signed'(h);
        sw = DATA_W'(sh);
        return sgn ? DATA_W'(sw) : {{(DATA_W-16){1'b0}}, h};
    endfunction

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_val = '0;
        case (funct3)
            F3_B:    load_val = ext_byte(byte_sel, 1'b1);
            F3_BU:   load_val = ext_byte(byte_sel, 1'b0);
            F3_H:    load_val = ext_half(half_sel, 1'b1);
            F3_HU:   load_val = ext_half(half_sel, 1'b0);
            F3_W:    load_val = word;
            default: load_val = '0;
        endcase
    end

    // Store merge: untouched lanes keep the word read in the RMW first step.
    always_comb begin
        store_word = word;
        case (funct3)
            F3_B: begin
                case (addr_lo)
                    2'd0: store_word[7:0]   = wdata[7:0];
                    2'd1: store_word[15:8]  = wdata[7:0];
                    2'd2: store_word[23:16] = wdata[7:0];
                    2'd3: store_word[31:24] = wdata[7:0];
                    default: store_word = word;
                endcase
            end
            F3_H: begin
                if (addr_lo[1]) store_word[31:16] = wdata[15:0];
                else            store_word[15:0]  = wdata[15:0];
            end
            F3_W:    store_word = wdata;
            default: store_word = word;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (funct3)
            F3_H, F3_HU: misaligned = addr_lo[0];
            F3_W:        misaligned = (addr_lo != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    end

    always_comb begin
        illegal = 1'b1;
        if (is_store) illegal = !(funct3 inside {F3_B, F3_H, F3_W});
        else          illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store sequencer in front of a word-only, combinational-read data memory;
// adds byte/halfword loads and read-modify-write sub-word stores.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    state_t            state, state_nxt;
    logic              accept;
    logic              go_err;
    logic [DATA_W-1:0] req_addr_eff;

    logic              write_p0;
    logic [2:0]        funct3_p0;
    logic [DATA_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic [DATA_W-1:0] word_p1;
    logic [DATA_W-1:0] rdata_p1;

    logic [1:0]        lane_lo;
    logic [2:0]        lane_f3;
    logic              lane_store;
    logic [DATA_W-1:0] lane_word;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] store_word;
    logic              misaligned;
    logic              illegal;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    // In IDLE the lane checker looks at the incoming request for the legality
    // decision; afterwards it works on the latched request.
    always_comb begin
        lane_lo    = addr_p0[1:0];
        lane_f3    = funct3_p0;
        lane_store = write_p0;
        if (state == IDLE) begin
            lane_lo    = req_addr[1:0];
            lane_f3    = req_funct3;
            lane_store = req_write;
        end
        lane_word = (state == WR) ? word_p1 : mem_read_data;
    end

    dmem_lane_align u_lane (
        .word       (lane_word),
        .addr_lo    (lane_lo),
        .funct3     (lane_f3),
        .is_store   (lane_store),
        .wdata      (wdata_p0),
        .load_val   (load_val),
        .store_word (store_word),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    assign go_err       = illegal || (misaligned && ERR_ON_MISALIGN);
    assign req_addr_eff = {req_addr[DATA_W-1:2], natural_align(req_funct3, req_addr[1:0])};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (go_err)                                state_nxt = ERR;
                    else if (req_write && req_funct3 == F3_W)  state_nxt = WR;
                    else                                       state_nxt = RD;
                end
            end
            RD:      state_nxt = write_p0 ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: request capture at accept
    always_ff @(posedge clk) begin
        if (rst) begin
            write_p0  <= 1'b0;
            funct3_p0 <= '0;
            addr_p0   <= '0;
            wdata_p0  <= '0;
        end else if (accept) begin
            write_p0  <= req_write;
            funct3_p0 <= req_funct3;
            addr_p0   <= req_addr_eff;
            wdata_p0  <= req_wdata;
        end
    end

    // Stage p1: memory word / extended load result capture in RD
    always_ff @(posedge clk) begin
        if (rst) begin
            word_p1  <= '0;
            rdata_p1 <= '0;
        end else if (accept) begin
            rdata_p1 <= '0;
        end else if (state == RD) begin
            if (write_p0) word_p1  <= mem_read_data;
            else          rdata_p1 <= load_val;
        end
    end

    always_comb begin
        resp_valid     = (state == RESP) || (state == ERR);
        resp_err       = (state == ERR);
        resp_rdata     = (state == RESP) ? rdata_p1 : '0;
        mem_read       = (state == RD);
        mem_write      = (state == WR) && !rst;
        mem_address    = '0;
        mem_write_data = '0;
        if (state == RD || state == WR) mem_address = {addr_p0[DATA_W-1:2], 2'b00};
        if (state == WR)                mem_write_data = store_word;
    end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store sequencer between the CPU memory stage and the word-only `dmem`.
- `dmem` supports only 32-bit writes and has a combinational read. This block adds byte and halfword access:
  - loads: lane select plus sign/zero extension;
  - sub-word stores: two-step read-modify-write.
- Checks alignment and funct3 legality.
- Handshake is valid/ready on the request side and a one-cycle response pulse on the result side.

Parameters:
- `ERR_ON_MISALIGN`, default 1.
  - 1: a misaligned access returns an error and never touches memory.
  - 0: the low address bits are forced to the natural alignment and the access proceeds.

Ports:
- `clk` input 1: system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request (high only in IDLE).
- `req_write` input 1: 1 = store, 0 = load.
- `req_funct3` input 3: RISC-V width/sign code.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-justified.
- `resp_valid` output 1: one-cycle completion pulse.
- `resp_err` output 1: valid with `resp_valid`; misaligned or illegal funct3.
- `resp_rdata` output 32: extended load data; 0 for stores and errors.
- `mem_read` output 1: to `dmem` `mem_read`.
- `mem_write` output 1: to `dmem` `mem_write`.
- `mem_address` output 32: to `dmem` `address`; word-aligned, bits [1:0] = 0.
- `mem_write_data` output 32: to `dmem` `write_data`.
- `mem_read_data` input 32: from `dmem` `read_data`; combinational, same cycle as `mem_read`.

Behaviour:
- Reset
  - At the `rst` edge: state = IDLE; `resp_valid`, `resp_err` = 0; `resp_rdata` = 0; all latched request fields = 0.
  - `mem_read`, `mem_write` and `mem_write_data` are 0 while in IDLE.
  - `mem_write` is gated by `!rst`, so a store in flight when `rst` rises writes nothing.
- Accept
  - A request is accepted on a clock edge where `req_valid` and `req_ready` are both high.
  - At acceptance, latch `req_write`, `req_funct3`, `req_addr` and `req_wdata`.
  - `req_ready` is low in every state except IDLE. Only one request is outstanding.
- Legal funct3 codes
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal and produces an error.
- Misalignment
  - Halfword: `addr[0]` = 1.
  - Word: `addr[1:0]` != 0.
  - Byte: never misaligned.
- States and transitions
  - IDLE -> ERR on accept when the funct3 is illegal, or when misaligned and `ERR_ON_MISALIGN` = 1.
  - IDLE -> RD for a load or for SB/SH.
  - IDLE -> WR for SW.
  - RD:
    - `mem_read` = 1, `mem_address` = `{addr[31:2], 2'b00}`.
    - Load: capture the extended lane into `resp_rdata`, then go to RESP.
    - SB/SH: latch the full word, then go to WR.
  - WR:
    - `mem_write` = 1.
    - `mem_write_data` = latched word with the byte/half lane replaced by `wdata[7:0]` or `wdata[15:0]`; SW uses `wdata` directly.
    - Next state RESP.
  - RESP: `resp_valid` = 1 for one cycle, `resp_err` = 0; next state IDLE.
  - ERR: `resp_valid` = 1, `resp_err` = 1, `resp_rdata` = 0, no memory strobes; next state IDLE.
- Lane selection
  - Byte lane = `addr[1:0]`; half lane = `addr[1]`.
  - Little-endian: byte 0 is bits [7:0].
- Latency, accept edge = cycle 0:
  - LW/LB/LH/LBU/LHU: `resp_valid` in cycle 2.
  - SW: write in cycle 1, `resp_valid` in cycle 2.
  - SB/SH: read in cycle 1, write in cycle 2, `resp_valid` in cycle 3.
  - Error: `resp_valid` in cycle 1.
- No response backpressure: the consumer must take `resp_valid` when it occurs.
- `req_ready` rises in the cycle after RESP/ERR.
- Back-to-back throughput: one request per (latency + 1) cycles.
- Request inputs are ignored outside IDLE. A changing `req_*` mid-operation has no effect.
- `mem_read` and `mem_write` are never both high.

Decomposition:
- Shared package/include `dmem_lsu_defs.vh`:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - state encodings (IDLE, RD, WR, RESP, ERR; 3 bits).
- One natural sub-module, `dmem_lane_align` (combinational). Inputs: word, `addr[1:0]`, funct3, `wdata`. Outputs:
  - the extended load value;
  - the merged store word;
  - the misaligned and illegal flags.

Test Plan:
- Aligned store/load: SW `0x0000_0010 <- 0xDEAD_BEEF`, then LW `0x10` -> WR with `mem_address` = `0x10`, `mem_write_data` = `0xDEADBEEF`; `resp_rdata` = `0xDEADBEEF` in cycle 2; `resp_err` = 0.
- Byte store with read-modify-write:
  - Preload word `0x10` = `0x1122_3344`, then SB addr `0x12` data `0xAB`.
  - Expect RD then WR with `mem_write_data` = `0x11AB_3344`; `resp_valid` in cycle 3.
- Sign extension:
  - Word = `0x80FF_7F01`.
  - LB `0x13` -> `0xFFFF_FF80`.
  - LBU `0x13` -> `0x0000_0080`.
  - LH `0x10` -> `0x0000_7F01`.
  - LHU `0x12` -> `0x0000_80FF`.
- Errors:
  - LW `0x11` -> ERR, `resp_err` = 1 in cycle 1, no `mem_read`/`mem_write` pulse.
  - funct3 = 011 -> same.
  - `ERR_ON_MISALIGN` = 0: LW `0x11` reads word `0x10` without error.
- Handshake: hold `req_valid` = 1 with three queued requests -> `req_ready` low in all non-IDLE cycles; exactly three responses; no request dropped or duplicated.
- Reset mid-operation: assert `rst` during the WR cycle of an SB -> `mem_write` = 0 that cycle, memory unchanged, state IDLE, `resp_valid` never pulses.
